product_accumulator: RTL and testbench
======================================

# product_accumulator

Sequential stage directly downstream of the 2x2 array multiplier. It accepts the multiplier's 4-bit product over a valid/ready handshake and sums `N` consecutive products into an `ACC_W`-bit accumulator. It presents each completed frame sum, with a sticky overflow flag, on an output valid/ready handshake. It turns the combinational multiplier into a small multiply-accumulate (dot-product) datapath.

## Interface
- `ACC_W`, 8: accumulator width in bits; legal range 4..16.
- `N`, 4: products per frame; legal range 1..255.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `clr` input 1: synchronous frame abort.
- `in_valid` input 1: `p` holds a valid product.
- `in_ready` output 1: block can accept a product; a transfer occurs on a cycle where `in_valid` and `in_ready` are both 1.
- `p` input 4: unsigned product from the multiplier, range 0..9.
- `out_valid` output 1: `acc` and `ovf` hold a completed frame.
- `out_ready` input 1: consumer accepts the frame.
- `acc` output ACC_W: running and final sum, unsigned.
- `ovf` output 1: sticky flag; set when the sum exceeded 2^ACC_W−1 during the current frame.

## Operation
- State register has three states: IDLE, ACCUM, DONE. The count register `cnt` is 8 bits wide.
- `in_ready` = 1 in IDLE and ACCUM and 0 in DONE. It is decoded from state only; it never depends on `in_valid`.
- `out_valid` = 1 exactly in DONE; it is registered.
- IDLE behaviour:
  - On a transfer: `acc` ← zero-extended `p`, `ovf` ← 0, `cnt` ← 1.
  - Next state is DONE if N = 1, otherwise ACCUM.
- ACCUM behaviour:
  - On a transfer: `{carry, acc}` ← `acc` + zero-extended `p`; `acc` wraps modulo 2^ACC_W; `ovf` ← `ovf` OR carry; `cnt` ← `cnt`+1.
  - When the incremented `cnt` equals N, next state is DONE.
  - Cycles without a transfer (bubbles) leave all registers unchanged.
- DONE behaviour:
  - `acc`, `ovf` and `cnt` are held stable while `out_valid` = 1 and `out_ready` = 0.
  - On `out_ready` = 1, next state is IDLE and `acc`, `ovf`, `cnt` are cleared to 0.
- `clr` = 1 in any state:
  - Next state is IDLE and `acc`, `ovf`, `cnt` are cleared to 0.
  - `clr` has priority over a simultaneous input transfer (the product is dropped) and over output acceptance (the frame is dropped).
- In IDLE and ACCUM, `acc` and `ovf` are visible as the running partial value. Consumers sample them only when `out_valid` = 1.
- Values of `p` above 9 are summed arithmetically like any other value; there is no range check.

## Timing
- Reset values: state IDLE, `acc` = 0, `ovf` = 0, `cnt` = 0, `out_valid` = 0.
  - `in_ready` reads 1 while `rst` is high, but transfers are ignored during reset.
- Reset asserted mid-frame or in DONE discards all state immediately, without waiting for a clock edge.
- Output latency: `out_valid` rises on the clock edge that accepts the N-th product. It is visible in the following cycle, together with the final `acc` and `ovf`.
- Throughput with `in_valid` and `out_ready` held at 1:
  - one frame per N+1 cycles;
  - one dead input cycle per frame (`in_ready` = 0 during DONE).
- No combinational path from any input to any output other than through the state register. `in_ready` depends on state only.
- Wrap-around: `cnt` never exceeds N, and it returns to 0 on leaving DONE.

## Test plan
- ACC_W = 8, N = 4: products 9, 9, 9, 9 back-to-back, `out_ready` = 1.
  - Required: `out_valid` in cycle 5, `acc` = 36, `ovf` = 0.
  - Required: `in_ready` = 0 for exactly that cycle; the next frame starts in cycle 6.
- ACC_W = 5, N = 4: four products of 9.
  - Required: `acc` = 4 (36 mod 32), `ovf` = 1.
  - Required: the next frame of 1, 1, 1, 1 gives `acc` = 4, `ovf` = 0 (flag cleared between frames).
- N = 4: products 2, 3, 6, 4 with 2-cycle bubbles between them, and `out_ready` held at 0 for 5 cycles after completion.
  - Required: `acc` = 15 held stable with `out_valid` = 1 throughout.
  - Required: `in_valid` pulses during DONE are ignored.
  - Required: IDLE is entered after `out_ready` rises.
- N = 4: products 9, 9, then `clr` = 1 in the same cycle as a third `in_valid` carrying 9.
  - Required: state returns to IDLE, `acc` = 0.
  - Required: the next four products of 1 give `acc` = 4.
- `rst` pulsed asynchronously, between clock edges, after two products in ACCUM and again while in DONE.
  - Required: `acc` = 0, `ovf` = 0, `out_valid` = 0 immediately.
  - Required: a following frame of 3, 3, 3, 3 gives `acc` = 12.
- N = 1: a stream of products 4, 9, 0.
  - Required: three frames with `acc` = 4, 9, 0, each presented with one-cycle latency.

Source files
------------

// File: rtl/product_accumulator.sv
// product_accumulator: sums N consecutive 4-bit multiplier products per frame and
// presents the frame total, with a sticky overflow flag, on a valid/ready output.
module product_accumulator #(
    parameter int ACC_W = 8,
    parameter int N     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc,
    output logic             ovf
);
    // state | meaning
    // IDLE  | waiting for the first product of a frame
    // ACCUM | summing products 2..N, bubbles hold everything
    // DONE  | frame total presented, waiting for out_ready
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         SUM_W = ACC_W + 1;
    localparam logic [7:0] N_CNT = 8'(N);

    state_t           state;
    logic [7:0]       cnt;
    logic [ACC_W:0]   sum;
    logic             xfer;
    logic             last;

    assign in_ready = (state != DONE);
    assign xfer     = in_valid && in_ready;
    // Top bit of sum is the carry out of the accumulator.
    assign sum      = {1'b0, acc} + SUM_W'(p);
    assign last     = (cnt + 8'd1) == N_CNT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            cnt       <= 8'd0;
            out_valid <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            cnt       <= 8'd0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        acc <= ACC_W'(p);
                        ovf <= 1'b0;
                        cnt <= 8'd1;
                        if (N == 1) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        acc <= sum[ACC_W-1:0];
                        ovf <= ovf | sum[ACC_W];
                        cnt <= cnt + 8'd1;
                        if (last) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        acc       <= '0;
                        ovf       <= 1'b0;
                        cnt       <= 8'd0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three instances (8-bit/N=4, 5-bit/N=4, 8-bit/N=1)
// driven by directed and random frames, checked against a frame-sum model.
module tb_product_accumulator;
    logic       clk;
    logic       rst;
    logic       clr       [3];
    logic       in_valid  [3];
    logic       in_ready_v[3];
    logic [3:0] p         [3];
    logic       out_valid_v[3];
    logic       out_ready [3];
    logic       ovf_v     [3];
    logic [7:0] acc0;
    logic [4:0] acc1;
    logic [7:0] acc2;
    logic [15:0] acc_v    [3];

    int n_cmp = 0;
    int n_err = 0;
    int widths [3] = '{8, 5, 8};

    assign acc_v[0] = {8'd0, acc0};
    assign acc_v[1] = {11'd0, acc1};
    assign acc_v[2] = {8'd0, acc2};

    product_accumulator #(.ACC_W(8), .N(4)) dut0 (
        .clk(clk), .rst(rst), .clr(clr[0]), .in_valid(in_valid[0]), .in_ready(in_ready_v[0]),
        .p(p[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready[0]), .acc(acc0), .ovf(ovf_v[0]));
    product_accumulator #(.ACC_W(5), .N(4)) dut1 (
        .clk(clk), .rst(rst), .clr(clr[1]), .in_valid(in_valid[1]), .in_ready(in_ready_v[1]),
        .p(p[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready[1]), .acc(acc1), .ovf(ovf_v[1]));
    product_accumulator #(.ACC_W(8), .N(1)) dut2 (
        .clk(clk), .rst(rst), .clr(clr[2]), .in_valid(in_valid[2]), .in_ready(in_ready_v[2]),
        .p(p[2]), .out_valid(out_valid_v[2]), .out_ready(out_ready[2]), .acc(acc2), .ovf(ovf_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame model: the total of the frame's products, reduced to the accumulator width.
    function automatic logic [31:0] exp_acc(input int sum, input int w);
        return 32'(sum % (1 << w));
    endfunction

    function automatic logic [31:0] exp_ovf(input int sum, input int w);
        return (sum >= (1 << w)) ? 32'd1 : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // All tasks start and end on a falling clock edge.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic push(input int idx, input int v);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            if (in_ready_v[idx]) begin
                in_valid[idx] = 1'b1;
                p[idx] = 4'(v);
                @(negedge clk);
                in_valid[idx] = 1'b0;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chk("push_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_valid(input int idx);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            if (out_valid_v[idx]) seen = 1'b1;
            else @(negedge clk);
        end
        chk("out_valid_timeout", {31'd0, seen}, 32'd1);
    endtask

    task automatic expect_frame(input int idx, input int sum, input string tag);
        wait_valid(idx);
        chk({tag, "_acc"}, 32'(acc_v[idx]), exp_acc(sum, widths[idx]));
        chk({tag, "_ovf"}, 32'(ovf_v[idx]), exp_ovf(sum, widths[idx]));
        chk({tag, "_in_ready_done"}, 32'(in_ready_v[idx]), 32'd0);
        out_ready[idx] = 1'b1;
        @(negedge clk);
        out_ready[idx] = 1'b0;
        chk({tag, "_released"}, 32'(out_valid_v[idx]), 32'd0);
        chk({tag, "_cleared"}, 32'(acc_v[idx]), 32'd0);
    endtask

    initial begin
        int sum;
        int vals [4];
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clr[i] = 1'b0; in_valid[i] = 1'b0; p[i] = 4'd0; out_ready[i] = 1'b0;
        end
        // transfers offered during reset must be ignored
        in_valid[0] = 1'b1;
        p[0] = 4'd9;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_in_ready", 32'(in_ready_v[i]), 32'd1);
            chk("reset_out_valid", 32'(out_valid_v[i]), 32'd0);
            chk("reset_acc", 32'(acc_v[i]), 32'd0);
            chk("reset_ovf", 32'(ovf_v[i]), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        chk("reset_ignores_xfer", 32'(acc_v[0]), 32'd0);
        in_valid[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // back-to-back 9s with out_ready held: DONE in cycle 5, next frame in cycle 6
        in_valid[0] = 1'b1; p[0] = 4'd9; out_ready[0] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c <= 3) chk("b2b_not_done", 32'(out_valid_v[0]), 32'd0);
            if (c == 4) begin
                chk("b2b_valid", 32'(out_valid_v[0]), 32'd1);
                chk("b2b_acc", 32'(acc_v[0]), exp_acc(4 * 9, 8));
                chk("b2b_ovf", 32'(ovf_v[0]), exp_ovf(4 * 9, 8));
                chk("b2b_dead_cycle", 32'(in_ready_v[0]), 32'd0);
            end
            if (c == 5) begin
                chk("b2b_valid_drop", 32'(out_valid_v[0]), 32'd0);
                chk("b2b_ready_back", 32'(in_ready_v[0]), 32'd1);
            end
            if (c == 6) chk("b2b_next_frame", 32'(acc_v[0]), 32'd9);
        end
        in_valid[0] = 1'b0; out_ready[0] = 1'b0; clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        chk("clr_cleanup", 32'(acc_v[0]), 32'd0);

        // overflow in a 5-bit accumulator, flag cleared for the next frame
        for (int k = 0; k < 4; k++) push(1, 9);
        expect_frame(1, 36, "ovf5");
        for (int k = 0; k < 4; k++) push(1, 1);
        expect_frame(1, 4, "ovf5_next");

        // bubbles, stalled output, ignored in_valid during DONE
        vals = '{2, 3, 6, 4};
        for (int k = 0; k < 4; k++) begin
            push(0, vals[k]);
            if (k < 3) idle(2);
        end
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 32'(out_valid_v[0]), 32'd1);
            chk("stall_acc", 32'(acc_v[0]), 32'd15);
            chk("stall_in_ready", 32'(in_ready_v[0]), 32'd0);
            in_valid[0] = k[0]; p[0] = 4'd9;
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        expect_frame(0, 15, "stall");
        chk("stall_idle", 32'(in_ready_v[0]), 32'd1);

        // clr beats a simultaneous transfer
        push(0, 9);
        push(0, 9);
        in_valid[0] = 1'b1; p[0] = 4'd9; clr[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0; clr[0] = 1'b0;
        chk("clr_acc", 32'(acc_v[0]), 32'd0);
        chk("clr_in_ready", 32'(in_ready_v[0]), 32'd1);
        for (int k = 0; k < 4; k++) push(0, 1);
        expect_frame(0, 4, "after_clr");

        // asynchronous reset in ACCUM and in DONE
        push(0, 3);
        push(0, 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_accum_acc", 32'(acc_v[0]), 32'd0);
        chk("arst_accum_ovf", 32'(ovf_v[0]), 32'd0);
        chk("arst_accum_valid", 32'(out_valid_v[0]), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) push(0, 3);
        wait_valid(0);
        #3 rst = 1'b1;
        #1;
        chk("arst_done_valid", 32'(out_valid_v[0]), 32'd0);
        chk("arst_done_acc", 32'(acc_v[0]), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) push(0, 3);
        expect_frame(0, 12, "after_arst");

        // N = 1: each product is a frame, presented one cycle later
        vals = '{4, 9, 0, 0};
        for (int k = 0; k < 3; k++) begin
            push(2, vals[k]);
            chk("n1_valid", 32'(out_valid_v[2]), 32'd1);
            expect_frame(2, vals[k], "n1");
        end

        // random frames on both N=4 instances with random bubbles and stalls
        for (int f = 0; f < 16; f++) begin
            int idx;
            int dly;
            idx = f % 2;
            sum = 0;
            for (int k = 0; k < 4; k++) begin
                int v;
                v = int'($urandom_range(0, 15));
                sum += v;
                push(idx, v);
                idle(int'($urandom_range(0, 2)));
            end
            wait_valid(idx);
            dly = int'($urandom_range(0, 3));
            for (int d = 0; d < dly; d++) begin
                @(negedge clk);
                chk("rand_hold", 32'(acc_v[idx]), exp_acc(sum, widths[idx]));
            end
            expect_frame(idx, sum, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
